// File: rtl/reservation_station_multi_if.sv
// Shared control type and the dispatch/issue/broadcast bundle for
// reservation_station_multi. The master is the dispatch/CDB/unit side and
// the slave is the reservation station.
package rs_multi_pkg;
  typedef struct packed {
    logic       is_sub;
    logic       use_carry;
    logic [1:0] fmt;
  } add_sub_decode_t;
endpackage

interface reservation_station_multi_if #(
  parameter int  OPERANDS      = 2,
  parameter int  OPERAND_WIDTH = 32,
  parameter int  RS_ID_WIDTH   = 5,
  parameter int  CDB_PORTS     = 2,
  parameter type CONTROL_TYPE  = rs_multi_pkg::add_sub_decode_t
);
  logic                                        take_valid;
  logic                                        take_ready;
  logic [OPERANDS-1:0]                         op_value_valid_in;
  logic [OPERANDS-1:0][RS_ID_WIDTH-1:0]        op_rs_id_in;
  logic [OPERANDS-1:0][OPERAND_WIDTH-1:0]      op_value_in;
  CONTROL_TYPE                                 control_in;
  logic [RS_ID_WIDTH-1:0]                      id_taken;
  logic [CDB_PORTS-1:0]                        cdb_valid;
  logic [CDB_PORTS-1:0][RS_ID_WIDTH-1:0]       cdb_rs_id;
  logic [CDB_PORTS-1:0][OPERAND_WIDTH-1:0]     cdb_value;
  logic                                        flush;
  logic                                        output_valid;
  logic                                        output_ready;
  logic [OPERANDS-1:0][OPERAND_WIDTH-1:0]      op_value_out;
  CONTROL_TYPE                                 control_out;
  logic [RS_ID_WIDTH-1:0]                      op_rs_id_out;

  modport master (
    output take_valid, op_value_valid_in, op_rs_id_in, op_value_in, control_in,
    output cdb_valid, cdb_rs_id, cdb_value, flush, output_ready,
    input  take_ready, id_taken, output_valid, op_value_out, control_out, op_rs_id_out
  );

  modport slave (
    input  take_valid, op_value_valid_in, op_rs_id_in, op_value_in, control_in,
    input  cdb_valid, cdb_rs_id, cdb_value, flush, output_ready,
    output take_ready, id_taken, output_valid, op_value_out, control_out, op_rs_id_out
  );
endinterface

// File: rtl/reservation_station_multi.sv
// Reservation station bank for one execution unit with CDB_PORTS broadcast
// buses, oldest-ready-first issue (age matrix) and a global flush.
// Optional feature: define RS_OCCUPANCY_EN to add the registered
// 'occupancy' output (count of non-INVALID entries).
module reservation_station_multi #(
  parameter int  OPERANDS      = 2,
  parameter int  OPERAND_WIDTH = 32,
  parameter int  RS_OFFSET     = 0,
  parameter int  RS_DEPTH      = 8,
  parameter int  RS_ID_WIDTH   = 5,
  parameter int  CDB_PORTS     = 2,
  parameter type CONTROL_TYPE  = rs_multi_pkg::add_sub_decode_t
) (
  input  logic                         clk,
  input  logic                         rst,
  reservation_station_multi_if.slave   bus
`ifdef RS_OCCUPANCY_EN
  ,
  output logic [$clog2(RS_DEPTH+1)-1:0] occupancy
`endif
);
  localparam int IDXW = $clog2(RS_DEPTH);
  localparam int OCCW = $clog2(RS_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_INVALID   = 2'd0,
    ST_VALID     = 2'd1,
    ST_EXECUTING = 2'd2
  } ent_state_e;

  ent_state_e  st_q   [RS_DEPTH];
  ent_state_e  st_d   [RS_DEPTH];
  CONTROL_TYPE ctrl_q [RS_DEPTH];
  CONTROL_TYPE ctrl_d [RS_DEPTH];
  logic [RS_DEPTH-1:0][OPERANDS-1:0]                    opv_q, opv_d;
  logic [RS_DEPTH-1:0][OPERANDS-1:0][OPERAND_WIDTH-1:0] opd_q, opd_d;
  logic [RS_DEPTH-1:0][OPERANDS-1:0][RS_ID_WIDTH-1:0]   tag_q, tag_d;
  // older_q[r][c] = 1 means entry r was allocated before entry c.
  // The diagonal is never set.
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]                    older_q, older_d;

  logic [RS_DEPTH-1:0] own_hit, free_mask, free_slot, ready, sel;
  logic                any_free, take_rdy, take_fire, disp_fire;
  logic [IDXW-1:0]     alloc_idx;

  // Per-entry view: own-ID hit on any CDB port, free/allocatable, issue-ready
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      own_hit[i] = 1'b0;
      for (int p = 0; p < CDB_PORTS; p++)
        if (bus.cdb_valid[p] && (bus.cdb_rs_id[p] == RS_ID_WIDTH'(i + RS_OFFSET)))
          own_hit[i] = 1'b1;
      free_mask[i] = (st_q[i] == ST_EXECUTING) && own_hit[i];
      free_slot[i] = (st_q[i] == ST_INVALID) || free_mask[i];
      ready[i]     = (st_q[i] == ST_VALID) && (&opv_q[i]);
    end
  end

  // Lowest-index allocatable entry (descending scan, last write wins)
  always_comb begin
    any_free  = 1'b0;
    alloc_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (free_slot[i]) begin
        any_free  = 1'b1;
        alloc_idx = IDXW'(i);
      end
  end

  assign take_rdy       = any_free && !bus.flush && rst;
  assign take_fire      = bus.take_valid && take_rdy;
  assign bus.take_ready = take_rdy;
  assign bus.id_taken   = RS_ID_WIDTH'(int'(alloc_idx) + RS_OFFSET);

  // Oldest ready entry: ready and no other ready entry is older than it
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      sel[i] = ready[i];
      for (int j = 0; j < RS_DEPTH; j++)
        if (ready[j] && older_q[j][i]) sel[i] = 1'b0;
    end
  end

  assign bus.output_valid = |ready;
  assign disp_fire        = (|ready) && bus.output_ready;

  // Issue mux; sel is one-hot, and all-zero yields zero outputs
  always_comb begin
    bus.op_value_out = '0;
    bus.control_out  = '0;
    bus.op_rs_id_out = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      if (sel[i]) begin
        bus.op_value_out = opd_q[i];
        bus.control_out  = ctrl_q[i];
        bus.op_rs_id_out = RS_ID_WIDTH'(i + RS_OFFSET);
      end
  end

  // Next state: issue, wakeup and free first, then allocation, and flush overrides all
  always_comb begin
    st_d    = st_q;
    ctrl_d  = ctrl_q;
    opv_d   = opv_q;
    opd_d   = opd_q;
    tag_d   = tag_q;
    older_d = older_q;

    for (int i = 0; i < RS_DEPTH; i++) begin
      if (st_q[i] == ST_VALID) begin
        if (disp_fire && sel[i]) st_d[i] = ST_EXECUTING;
        // Wakeup: the lowest matching port wins (descending scan)
        for (int k = 0; k < OPERANDS; k++)
          if (!opv_q[i][k])
            for (int p = CDB_PORTS - 1; p >= 0; p--)
              if (bus.cdb_valid[p] && (bus.cdb_rs_id[p] == tag_q[i][k])) begin
                opv_d[i][k] = 1'b1;
                opd_d[i][k] = bus.cdb_value[p];
              end
      end
      if (free_mask[i]) begin
        st_d[i] = ST_INVALID;
        for (int j = 0; j < RS_DEPTH; j++) begin
          older_d[i][j] = 1'b0;
          older_d[j][i] = 1'b0;
        end
      end
    end

    if (take_fire)
      for (int i = 0; i < RS_DEPTH; i++)
        if (int'(alloc_idx) == i) begin
          st_d[i]   = ST_VALID;
          ctrl_d[i] = bus.control_in;
          for (int k = 0; k < OPERANDS; k++) begin
            opv_d[i][k] = bus.op_value_valid_in[k];
            opd_d[i][k] = bus.op_value_in[k];
            tag_d[i][k] = bus.op_rs_id_in[k];
            // Capture a result broadcast in the same cycle as the take
            if (!bus.op_value_valid_in[k])
              for (int p = CDB_PORTS - 1; p >= 0; p--)
                if (bus.cdb_valid[p] && (bus.cdb_rs_id[p] == bus.op_rs_id_in[k])) begin
                  opv_d[i][k] = 1'b1;
                  opd_d[i][k] = bus.cdb_value[p];
                end
          end
          // The new entry is the youngest: nothing is younger than it,
          // and every other entry is older than it.
          for (int j = 0; j < RS_DEPTH; j++) begin
            older_d[i][j] = 1'b0;
            older_d[j][i] = (j != i);
          end
        end

    if (bus.flush) begin
      for (int i = 0; i < RS_DEPTH; i++) st_d[i] = ST_INVALID;
      older_d = '0;
    end
  end

  // Entry storage and age matrix
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        st_q[i]   <= ST_INVALID;
        ctrl_q[i] <= '0;
      end
      opv_q   <= '0;
      opd_q   <= '0;
      tag_q   <= '0;
      older_q <= '0;
    end else begin
      st_q    <= st_d;
      ctrl_q  <= ctrl_d;
      opv_q   <= opv_d;
      opd_q   <= opd_d;
      tag_q   <= tag_d;
      older_q <= older_d;
    end
  end

`ifdef RS_OCCUPANCY_EN
  logic [OCCW-1:0] occ_q, occ_d, free_cnt;

  // Live-entry count: +1 per take, -1 per CDB free, cleared by flush
  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < RS_DEPTH; i++) free_cnt = free_cnt + OCCW'(free_mask[i]);
    occ_d = bus.flush ? '0 : (occ_q + OCCW'(take_fire) - free_cnt);
  end

  // Occupancy register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occ_q <= '0;
    else      occ_q <= occ_d;
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_reservation_station_multi.sv
// Directed bench for reservation_station_multi (RS_OFFSET=8, depth 8, 2 CDB ports).
// Inputs are driven at the falling edge; outputs are sampled 1 time unit later.
module tb_reservation_station_multi;
  import rs_multi_pkg::*;

  localparam int OPS = 2, OW = 32, OFF = 8, DEP = 8, IDW = 5, CDBP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec = 0;
  int   mis = 0;

  reservation_station_multi_if #(.OPERANDS(OPS), .OPERAND_WIDTH(OW), .RS_ID_WIDTH(IDW),
    .CDB_PORTS(CDBP), .CONTROL_TYPE(add_sub_decode_t)) bus ();

`ifdef RS_OCCUPANCY_EN
  logic [3:0] occupancy;
`endif

  reservation_station_multi #(.OPERANDS(OPS), .OPERAND_WIDTH(OW), .RS_OFFSET(OFF),
    .RS_DEPTH(DEP), .RS_ID_WIDTH(IDW), .CDB_PORTS(CDBP), .CONTROL_TYPE(add_sub_decode_t)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RS_OCCUPANCY_EN
    ,
    .occupancy (occupancy)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.take_valid = 1'b0; bus.op_value_valid_in = '0; bus.op_rs_id_in = '0;
    bus.op_value_in = '0; bus.control_in = '0; bus.cdb_valid = '0; bus.cdb_rs_id = '0;
    bus.cdb_value = '0; bus.flush = 1'b0; bus.output_ready = 1'b0;
  endtask

  task automatic set_take(input logic [1:0] vm, input logic [4:0] t0, input logic [4:0] t1,
                          input logic [31:0] v0, input logic [31:0] v1, input logic [3:0] c);
    bus.take_valid = 1'b1; bus.op_value_valid_in = vm;
    bus.op_rs_id_in[0] = t0; bus.op_rs_id_in[1] = t1;
    bus.op_value_in[0] = v0; bus.op_value_in[1] = v1;
    bus.control_in = c;
  endtask

  task automatic set_cdb(input int p, input logic [4:0] id, input logic [31:0] v);
    bus.cdb_valid[p] = 1'b1; bus.cdb_rs_id[p] = id; bus.cdb_value[p] = v;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    #2 rst = 1'b0;
    @(negedge clk); #1;
    vec++; if (bus.take_ready !== 1'b0) begin mis++; $display("FAIL reset_take_ready got %b want 0", bus.take_ready); end
    vec++; if (bus.output_valid !== 1'b0) begin mis++; $display("FAIL reset_output_valid got %b want 0", bus.output_valid); end
    vec++; if (bus.op_rs_id_out !== 5'd0) begin mis++; $display("FAIL reset_op_rs_id_out got %0d want 0", bus.op_rs_id_out); end
    vec++; if (bus.op_value_out !== 64'd0) begin mis++; $display("FAIL reset_op_value_out got %h want 0", bus.op_value_out); end
`ifdef RS_OCCUPANCY_EN
    vec++; if (occupancy !== 4'd0) begin mis++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
`endif
    rst = 1'b1; #1;
    vec++; if (bus.take_ready !== 1'b1) begin mis++; $display("FAIL release_take_ready got %b want 1", bus.take_ready); end
    vec++; if (bus.id_taken !== 5'd8) begin mis++; $display("FAIL release_id_taken got %0d want 8", bus.id_taken); end
  endtask

  task automatic test_fill_drain();
    logic [3:0] cg;
    do_reset();
    bus.output_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      set_take(2'b11, 5'd0, 5'd0, 32'(100 + n), 32'(200 + n), 4'(n));
      #1;
      vec++; if (bus.take_ready !== 1'b1) begin mis++; $display("FAIL fill_take_ready[%0d] got %b want 1", n, bus.take_ready); end
      vec++; if (bus.id_taken !== 5'(OFF + n)) begin mis++; $display("FAIL fill_id_taken[%0d] got %0d want %0d", n, bus.id_taken, OFF + n); end
      if (n > 0) begin
        vec++; if (bus.output_valid !== 1'b1) begin mis++; $display("FAIL fill_output_valid[%0d] got %b want 1", n, bus.output_valid); end
        vec++; if (bus.op_rs_id_out !== 5'(OFF + n - 1)) begin mis++; $display("FAIL fill_dispatch_id[%0d] got %0d want %0d", n, bus.op_rs_id_out, OFF + n - 1); end
        vec++; if (bus.op_value_out[0] !== 32'(100 + n - 1)) begin mis++; $display("FAIL fill_dispatch_op0[%0d] got %0d want %0d", n, bus.op_value_out[0], 100 + n - 1); end
      end
    end
    @(negedge clk); idle(); bus.output_ready = 1'b1; #1;
    cg = bus.control_out;
    vec++; if (bus.take_ready !== 1'b0) begin mis++; $display("FAIL full_take_ready got %b want 0", bus.take_ready); end
    vec++; if (bus.op_rs_id_out !== 5'd15) begin mis++; $display("FAIL last_dispatch_id got %0d want 15", bus.op_rs_id_out); end
    vec++; if (bus.op_value_out[1] !== 32'd207) begin mis++; $display("FAIL last_dispatch_op1 got %0d want 207", bus.op_value_out[1]); end
    vec++; if (cg !== 4'd7) begin mis++; $display("FAIL last_dispatch_ctrl got %0d want 7", cg); end
    @(negedge clk); idle(); #1;
    vec++; if (bus.output_valid !== 1'b0) begin mis++; $display("FAIL drained_output_valid got %b want 0", bus.output_valid); end
`ifdef RS_OCCUPANCY_EN
    vec++; if (occupancy !== 4'd8) begin mis++; $display("FAIL full_occupancy got %0d want 8", occupancy); end
`endif
    // Full bank: a same-cycle CDB free on ID 12 makes entry 4 allocatable
    @(negedge clk); set_cdb(0, 5'd12, 32'd0); set_take(2'b11, 5'd0, 5'd0, 32'h55, 32'h66, 4'd3); #1;
    vec++; if (bus.take_ready !== 1'b1) begin mis++; $display("FAIL free_take_ready got %b want 1", bus.take_ready); end
    vec++; if (bus.id_taken !== 5'd12) begin mis++; $display("FAIL free_id_taken got %0d want 12", bus.id_taken); end
    @(negedge clk); idle(); #1;
    vec++; if (bus.op_rs_id_out !== 5'd12 || bus.output_valid !== 1'b1) begin mis++; $display("FAIL realloc_dispatch got v=%b id=%0d want v=1 id=12", bus.output_valid, bus.op_rs_id_out); end
    vec++; if (bus.op_value_out[0] !== 32'h55) begin mis++; $display("FAIL realloc_op0 got %h want 55", bus.op_value_out[0]); end
`ifdef RS_OCCUPANCY_EN
    vec++; if (occupancy !== 4'd8) begin mis++; $display("FAIL take_free_net_occupancy got %0d want 8", occupancy); end
`endif
    // Free the remaining executing entries, two per cycle
    @(negedge clk); idle(); set_cdb(0, 5'd8, 0);  set_cdb(1, 5'd9, 0);
    @(negedge clk); idle(); set_cdb(0, 5'd10, 0); set_cdb(1, 5'd11, 0);
    @(negedge clk); idle(); set_cdb(0, 5'd13, 0); set_cdb(1, 5'd14, 0);
    @(negedge clk); idle(); set_cdb(0, 5'd15, 0);
    @(negedge clk); idle(); #1;
    vec++; if (bus.take_ready !== 1'b1 || bus.id_taken !== 5'd8) begin mis++; $display("FAIL freed_alloc got r=%b id=%0d want r=1 id=8", bus.take_ready, bus.id_taken); end
`ifdef RS_OCCUPANCY_EN
    vec++; if (occupancy !== 4'd1) begin mis++; $display("FAIL freed_occupancy got %0d want 1", occupancy); end
`endif
  endtask

  task automatic test_age_priority();
    logic [3:0] cg;
    do_reset();
    @(negedge clk); set_take(2'b10, 5'd28, 5'd0, 0, 0, 4'd0); #1;
    vec++; if (bus.id_taken !== 5'd8) begin mis++; $display("FAIL age_w0_id got %0d want 8", bus.id_taken); end
    @(negedge clk); set_take(2'b10, 5'd29, 5'd0, 0, 0, 4'd0);
    @(negedge clk); set_take(2'b10, 5'd30, 5'd0, 0, 0, 4'd0);
    @(negedge clk); set_take(2'b10, 5'd20, 5'd0, 0, 32'h5, 4'hA); #1;
    vec++; if (bus.id_taken !== 5'd11) begin mis++; $display("FAIL age_A_id got %0d want 11", bus.id_taken); end
    @(negedge clk); idle(); set_cdb(0, 5'd28, 32'h1); #1;
    vec++; if (bus.output_valid !== 1'b0) begin mis++; $display("FAIL age_none_ready got %b want 0", bus.output_valid); end
    @(negedge clk); idle(); bus.output_ready = 1'b1; #1;
    vec++; if (bus.output_valid !== 1'b1 || bus.op_rs_id_out !== 5'd8) begin mis++; $display("FAIL age_w0_dispatch got v=%b id=%0d want v=1 id=8", bus.output_valid, bus.op_rs_id_out); end
    // Free entry 0 and re-take B into it in the same cycle
    @(negedge clk); idle(); set_cdb(0, 5'd8, 0); set_take(2'b11, 0, 0, 32'hB0, 32'hB1, 4'hB); #1;
    vec++; if (bus.take_ready !== 1'b1 || bus.id_taken !== 5'd8) begin mis++; $display("FAIL age_B_alloc got r=%b id=%0d want r=1 id=8", bus.take_ready, bus.id_taken); end
    @(negedge clk); idle(); set_cdb(0, 5'd20, 32'h1234); bus.output_ready = 1'b1; #1;
    vec++; if (bus.op_rs_id_out !== 5'd8 || bus.op_value_out[0] !== 32'hB0) begin mis++; $display("FAIL age_B_first got id=%0d op0=%h want id=8 op0=b0", bus.op_rs_id_out, bus.op_value_out[0]); end
    @(negedge clk); idle(); bus.output_ready = 1'b1; #1;
    cg = bus.control_out;
    vec++; if (bus.op_rs_id_out !== 5'd11 || bus.output_valid !== 1'b1) begin mis++; $display("FAIL age_A_dispatch got v=%b id=%0d want v=1 id=11", bus.output_valid, bus.op_rs_id_out); end
    vec++; if (bus.op_value_out[0] !== 32'h1234 || bus.op_value_out[1] !== 32'h5) begin mis++; $display("FAIL age_A_ops got %h/%h want 1234/5", bus.op_value_out[0], bus.op_value_out[1]); end
    vec++; if (cg !== 4'hA) begin mis++; $display("FAIL age_A_ctrl got %h want a", cg); end
    // C ready in entry 4; then D into lower-index entry 0 is younger than C
    @(negedge clk); idle(); set_take(2'b11, 0, 0, 32'hC0, 32'hC1, 4'hC); #1;
    vec++; if (bus.id_taken !== 5'd12) begin mis++; $display("FAIL age_C_id got %0d want 12", bus.id_taken); end
    @(negedge clk); idle(); set_cdb(1, 5'd8, 0); set_take(2'b11, 0, 0, 32'hD0, 32'hD1, 4'hD); #1;
    vec++; if (bus.id_taken !== 5'd8 || bus.op_rs_id_out !== 5'd12) begin mis++; $display("FAIL age_D_alloc got id_taken=%0d out=%0d want 8/12", bus.id_taken, bus.op_rs_id_out); end
    @(negedge clk); idle(); bus.output_ready = 1'b1; #1;
    vec++; if (bus.op_rs_id_out !== 5'd12) begin mis++; $display("FAIL age_older_wins got %0d want 12", bus.op_rs_id_out); end
    @(negedge clk); idle(); #1;
    vec++; if (bus.op_rs_id_out !== 5'd8 || bus.op_value_out[0] !== 32'hD0) begin mis++; $display("FAIL age_D_next got id=%0d op0=%h want 8/d0", bus.op_rs_id_out, bus.op_value_out[0]); end
  endtask

  task automatic test_multi_wakeup();
    do_reset();
    @(negedge clk); set_take(2'b00, 5'd5, 5'd6, 0, 0, 4'd1);
    @(negedge clk); idle(); set_cdb(0, 5'd5, 32'hAA); set_cdb(1, 5'd6, 32'hBB); #1;
    vec++; if (bus.output_valid !== 1'b0) begin mis++; $display("FAIL wake_registered got %b want 0", bus.output_valid); end
    @(negedge clk); idle(); #1;
    vec++; if (bus.output_valid !== 1'b1) begin mis++; $display("FAIL wake_valid got %b want 1", bus.output_valid); end
    vec++; if (bus.op_value_out[0] !== 32'hAA || bus.op_value_out[1] !== 32'hBB) begin mis++; $display("FAIL wake_ops got %h/%h want aa/bb", bus.op_value_out[0], bus.op_value_out[1]); end
  endtask

  task automatic test_capture();
    do_reset();
    @(negedge clk); set_take(2'b01, 5'd0, 5'd4, 32'h11, 0, 4'd2); set_cdb(0, 5'd3, 32'h99); set_cdb(1, 5'd4, 32'h77);
    @(negedge clk); idle(); bus.output_ready = 1'b1;
    set_take(2'b10, 5'd7, 5'd0, 0, 32'h22, 4'd3); set_cdb(0, 5'd7, 32'hC0); set_cdb(1, 5'd7, 32'hC1); #1;
    vec++; if (bus.output_valid !== 1'b1 || bus.op_rs_id_out !== 5'd8) begin mis++; $display("FAIL cap_ready got v=%b id=%0d want v=1 id=8", bus.output_valid, bus.op_rs_id_out); end
    vec++; if (bus.op_value_out[1] !== 32'h77 || bus.op_value_out[0] !== 32'h11) begin mis++; $display("FAIL cap_ops got %h/%h want 11/77", bus.op_value_out[0], bus.op_value_out[1]); end
    vec++; if (bus.id_taken !== 5'd9) begin mis++; $display("FAIL cap_second_id got %0d want 9", bus.id_taken); end
    @(negedge clk); idle(); #1;
    vec++; if (bus.op_rs_id_out !== 5'd9 || bus.op_value_out[0] !== 32'hC0) begin mis++; $display("FAIL cap_low_port got id=%0d op0=%h want 9/c0", bus.op_rs_id_out, bus.op_value_out[0]); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk); set_take(2'b11, 0, 0, 32'(n), 32'(n), 4'(n));
    end
    @(negedge clk); idle(); bus.flush = 1'b1; bus.output_ready = 1'b1;
    set_take(2'b11, 0, 0, 32'h9, 32'h9, 4'd9); #1;
    vec++; if (bus.take_ready !== 1'b0) begin mis++; $display("FAIL flush_take_ready got %b want 0", bus.take_ready); end
    vec++; if (bus.output_valid !== 1'b1 || bus.op_rs_id_out !== 5'd8) begin mis++; $display("FAIL flush_cycle_out got v=%b id=%0d want v=1 id=8", bus.output_valid, bus.op_rs_id_out); end
`ifdef RS_OCCUPANCY_EN
    vec++; if (occupancy !== 4'd5) begin mis++; $display("FAIL preflush_occupancy got %0d want 5", occupancy); end
`endif
    @(negedge clk); idle(); #1;
    vec++; if (bus.output_valid !== 1'b0) begin mis++; $display("FAIL postflush_output_valid got %b want 0", bus.output_valid); end
`ifdef RS_OCCUPANCY_EN
    vec++; if (occupancy !== 4'd0) begin mis++; $display("FAIL postflush_occupancy got %0d want 0", occupancy); end
`endif
    for (int n = 0; n < 8; n++) begin
      if (n > 0) @(negedge clk);
      set_take(2'b11, 0, 0, 32'(n), 32'(n), 4'(n)); #1;
      vec++; if (bus.take_ready !== 1'b1 || bus.id_taken !== 5'(OFF + n)) begin mis++; $display("FAIL postflush_free[%0d] got r=%b id=%0d want r=1 id=%0d", n, bus.take_ready, bus.id_taken, OFF + n); end
    end
    @(negedge clk); idle(); #1;
    vec++; if (bus.take_ready !== 1'b0) begin mis++; $display("FAIL refill_full got %b want 0", bus.take_ready); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); idle(); #1;
    vec++; if (bus.output_valid !== 1'b1 || bus.op_rs_id_out !== 5'd8) begin mis++; $display("FAIL prereset_out got v=%b id=%0d want v=1 id=8", bus.output_valid, bus.op_rs_id_out); end
    #1 rst = 1'b0; #1;
    vec++; if (bus.output_valid !== 1'b0 || bus.take_ready !== 1'b0) begin mis++; $display("FAIL async_reset got v=%b r=%b want 0/0", bus.output_valid, bus.take_ready); end
    vec++; if (bus.op_value_out !== 64'd0) begin mis++; $display("FAIL async_reset_ops got %h want 0", bus.op_value_out); end
    @(negedge clk); rst = 1'b1; #1;
    vec++; if (bus.take_ready !== 1'b1 || bus.id_taken !== 5'd8) begin mis++; $display("FAIL after_reset got r=%b id=%0d want r=1 id=8", bus.take_ready, bus.id_taken); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_age_priority();
    test_multi_wakeup();
    test_capture();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule

// File: doc/reservation_station_multi.md
Name: reservation_station_multi

Overview:
- Next-generation reservation station bank for one execution unit; sits between dispatch/decode and the unit.
- Generalised to CDB_PORTS result-broadcast buses. Any operand matches on any bus.
- Dispatch is oldest-ready-first instead of lowest-index.
- Adds a global flush for mispredict/exception recovery.

Parameters:
- OPERANDS, 2, operands per instruction.
- OPERAND_WIDTH, 32, operand bit width.
- RS_OFFSET, 0, first global RS ID owned by this bank.
- RS_DEPTH, 8, entries in this bank (2..16).
- RS_ID_WIDTH, 5, global RS ID width.
- CDB_PORTS, 2, number of result-broadcast buses (1..4).
- CONTROL_TYPE, add_sub_decode_t, unit control struct.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- take_valid  in  1  new instruction offered.
- take_ready  out  1  a free entry exists and no flush is active.
- op_value_valid_in  in  OPERANDS x 1  operand value already known.
- op_rs_id_in  in  OPERANDS x RS_ID_WIDTH  producer RS ID when value unknown.
- op_value_in  in  OPERANDS x OPERAND_WIDTH  operand value.
- control_in  in  CONTROL_TYPE  control word.
- id_taken  out  RS_ID_WIDTH  global ID of the entry allocated this cycle.
- cdb_valid  in  CDB_PORTS x 1  broadcast valid.
- cdb_rs_id  in  CDB_PORTS x RS_ID_WIDTH  producer ID of broadcast.
- cdb_value  in  CDB_PORTS x OPERAND_WIDTH  broadcast result.
- flush  in  1  discard all entries.
- output_valid  out  1  a ready entry is presented.
- output_ready  in  1  unit accepts.
- op_value_out  out  OPERANDS x OPERAND_WIDTH  operands of the dispatched entry.
- control_out  out  CONTROL_TYPE  control of the dispatched entry.
- op_rs_id_out  out  RS_ID_WIDTH  global ID of the dispatched entry.

Behaviour:
- Entry states: INVALID -> VALID (on take) -> EXECUTING (on dispatch handshake) -> INVALID (when any cdb port carries its own ID).
- Reset (rst low, async): all entries INVALID; age order cleared; take_ready=0 while reset is held; output_valid=0; outputs are 0.
- Allocation:
  - Lowest-index entry that is INVALID, or EXECUTING with a same-cycle cdb match on its own ID.
  - id_taken = index + RS_OFFSET; combinational, valid whenever take_ready=1.
  - take_ready = free exists AND !flush.
- Capture on take: for each operand with op_value_valid_in=0, if any cdb port is valid with rs_id == op_rs_id_in, store that value as valid. Lowest cdb index wins if more than one matches.
- Wakeup: each VALID entry operand not yet valid compares against all CDB_PORTS every cycle; on a match the value is latched the next edge.
- A new entry becomes youngest. Age order is maintained as an age matrix; freeing an entry removes it from the order.
- Dispatch:
  - Oldest entry that is VALID with all operands valid (state as registered, not same-cycle wakeup).
  - Outputs are combinational from that entry.
  - Entry goes to EXECUTING on output_valid && output_ready.
  - With output_ready=0, output_valid stays 1 and outputs stay stable unless an older entry becomes ready (permitted to switch).
- Flush: next edge sets all entries INVALID and clears the age order. A take in the same cycle is ignored (take_ready=0). A dispatch handshake in the same cycle still completes at the unit, but the entry is freed. CDB updates in the flush cycle are dropped.
- Full: take_ready=0 unless a same-cycle free via cdb exists.
- Empty: output_valid=0.
- Simultaneous take + dispatch + free in one cycle are independent and all take effect.
- ID arithmetic is modulo 2^RS_ID_WIDTH. IDs outside [RS_OFFSET, RS_OFFSET+RS_DEPTH) never free entries here.

Optional Feature:
- Macro RS_OCCUPANCY_EN.
- When defined, adds output occupancy (clog2(RS_DEPTH+1) bits): registered count of non-INVALID entries.
  - Reset value 0.
  - +1 per take, -1 per free; simultaneous take and free nets to 0.
  - Goes to 0 on flush.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Fill-and-drain: RS_OFFSET=8, DEPTH=8, 8 takes with all operands valid, output_ready=1 -> id_taken 8..15 in order; take_ready=0 after the 8th; dispatch IDs 8..15 in age order.
- Age priority: take A into entry 3 (waiting on ID 20), then B into entry 0 (ready); cdb0 broadcasts ID 20 value 0x1234 -> B dispatches first. After A wakes, A dispatches with op0=0x1234.
- Multi-port wakeup: entry waiting op0 on ID 5 and op1 on ID 6; cdb0=(5,0xAA) and cdb1=(6,0xBB) in the same cycle -> output_valid next cycle with ops 0xAA/0xBB.
- Capture on take: take with op1 invalid on ID 4 while cdb1=(4,0x77) -> entry is ready immediately; dispatch the next cycle with op1=0x77.
- Flush: 5 entries live, flush=1 with take_valid=1 -> take_ready=0 that cycle; next cycle output_valid=0 and 8 free entries (occupancy=0 if RS_OCCUPANCY_EN).
- Async reset mid-stream: drop rst between edges -> output_valid=0 and take_ready=0 immediately; after release, take_ready=1 and id_taken=RS_OFFSET.
